pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter and sequences instruction fetch around the branch unit's redirect decision. Each cycle it advances the PC by 4, holds it on a hazard stall, or loads the branch/jump/halt target resolved in EX, and it flushes the younger pipeline stages on every redirect. A halt is handled with a drain phase, so older instructions retire before the sequencer parks, and a resume input restarts fetch.

## Interface
- PC_W, 9, width of the PC register (instruction address bits)
- DRAIN_CYC, 2, cycles to wait after halt for older instructions (MEM, WB) to retire; must be ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit requests PC/IF hold
- redirect  in  1  branch unit PcSel: take redirect_pc
- halt  in  1  halt instruction resolved in EX
- redirect_pc  in  32  branch unit BrPC target
- resume  in  1  leave HALTED; single-cycle pulse
- pc  out  PC_W  current fetch address (registered)
- fetch_valid  out  1  pc is a valid fetch this cycle
- flush_if_id  out  1  squash IF/ID register at next edge
- flush_id_ex  out  1  squash ID/EX register at next edge
- draining  out  1  in DRAIN state
- halted  out  1  in HALTED state
- redirect_cnt  out  32  taken-redirect count (see Configuration)
- stall_cnt  out  32  stalled-cycle count (see Configuration)

## Operation
- States: RUN, DRAIN, HALTED. Reset → RUN, pc=0, drain counter=0, counters=0.
- RUN, priority halt > redirect > stall > advance:
  - halt: pc ← redirect_pc[PC_W-1:0]; flush_if_id=flush_id_ex=1 this cycle; counter ← DRAIN_CYC-1; → DRAIN.
  - redirect: pc ← redirect_pc[PC_W-1:0]; both flushes=1 this cycle; stay in RUN. A redirect overrides a stall in the same cycle.
  - stall: pc holds; no flush.
  - else: pc ← pc+4, modulo 2^PC_W (wraps).
  - fetch_valid=1 in RUN.
- DRAIN: pc holds; fetch_valid=0; flush_if_id=1; flush_id_ex=0; stall, redirect, halt and resume are ignored. The counter decrements each cycle. In the cycle the counter is 0 → HALTED.
- HALTED: pc holds; fetch_valid=0; flush_if_id=1; flush_id_ex=0. resume=1 → pc ← pc+4, → RUN. All other inputs are ignored.
- resume outside HALTED is ignored.
- redirect_pc upper bits [31:PC_W] are discarded. Low bits [1:0] are loaded unchanged (no alignment check).
- Asynchronous reset mid-DRAIN or in HALTED returns to RUN with pc=0 immediately.

## Timing
- All outputs are valid after reset assertion: pc=0, fetch_valid=1, flush_if_id=0, flush_id_ex=0, draining=0, halted=0, redirect_cnt=0, stall_cnt=0.
- pc, draining and halted are registered.
- fetch_valid and both flushes are combinational from the state and the current-cycle inputs.
- Redirect latency: target appears on pc one edge after redirect is sampled. Exactly one wrong-path fetch is squashed by flush_if_id; the instruction in ID is squashed by flush_id_ex.
- Halt to halted=1: DRAIN_CYC+1 edges. draining=1 for DRAIN_CYC cycles.
- Resume to fetch_valid=1: one edge.

## Configuration
- PC_SEQUENCER_PERF_EN defined:
  - redirect_cnt increments on each RUN-state redirect or halt.
  - stall_cnt increments on each RUN cycle with stall=1 and no redirect or halt.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and are cleared by reset.
- Undefined: counter logic is absent and both outputs are tied to 0.

## Structure
- Package pc_sequencer_pkg holds:
  - typedef enum logic [1:0] seq_state_t {RUN, DRAIN, HALTED}
  - localparam PC_STEP = 4
  - localparam CNT_W = 32
- Sub-module pc_sequencer_perf holds the two saturating counters. It is instantiated only under PC_SEQUENCER_PERF_EN.

## Test plan
- Reset, then 5 free cycles, no stall → pc sequence 0,4,8,12,16,20; fetch_valid=1 throughout; no flush.
- PC_W=9 at pc=508, advance → pc=0 (wrap).
- At pc=8, stall=1 and redirect=1 with redirect_pc=0x0000_0240 → both flushes=1 that cycle; next pc=0x040 (bit 9 dropped); redirect_cnt=1 with PERF_EN.
- stall held 3 cycles at pc=12 → pc stays 12; stall_cnt=3; then pc=16.
- halt with redirect_pc=0x20, DRAIN_CYC=2 → next pc=0x20; draining=1 for 2 cycles; halted=1 on the 3rd edge; a redirect pulse during DRAIN has no effect; resume → pc=0x24, fetch_valid=1.
- rst_n low during DRAIN → immediately pc=0, draining=0, halted=0, counters=0; after release, normal fetch from 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and constants for the PC sequencer.
// Holds the FSM state enum, the PC step and the perf counter width.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } seq_state_t;

   localparam int PC_STEP = 4;
   localparam int CNT_W   = 32;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between the pipeline and the sequencer.
// master drives stall/redirect/halt/redirect_pc/resume; slave drives pc, flushes, status, counters.
interface pc_sequencer_if
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W = 9
);

   logic             stall;
   logic             redirect;
   logic             halt;
   logic [31:0]      redirect_pc;
   logic             resume;
   logic [PC_W-1:0]  pc;
   logic             fetch_valid;
   logic             flush_if_id;
   logic             flush_id_ex;
   logic             draining;
   logic             halted;
   logic [CNT_W-1:0] redirect_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output stall, redirect, halt, redirect_pc, resume,
      input  pc, fetch_valid, flush_if_id, flush_id_ex,
      input  draining, halted, redirect_cnt, stall_cnt
   );

   modport slave (
      input  stall, redirect, halt, redirect_pc, resume,
      output pc, fetch_valid, flush_if_id, flush_id_ex,
      output draining, halted, redirect_cnt, stall_cnt
   );

endinterface

// File: rtl/pc_sequencer_perf.sv
// pc_sequencer_perf: saturating taken-redirect and stalled-cycle counters.
// Ports: clk, rst_n, redirect_ev, stall_ev in; redirect_cnt, stall_cnt out.
module pc_sequencer_perf
   import pc_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             redirect_ev,
   input  logic             stall_ev,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_cnt <= '0;
         stall_cnt    <= '0;
      end else begin
         if (redirect_ev && (redirect_cnt != '1))
            redirect_cnt <= redirect_cnt + 1'b1;
         if (stall_ev && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC; advances, holds, redirects, drains on halt and parks.
// Ports: clk, rst_n, bus (slave). Perf counters built only with PC_SEQUENCER_PERF_EN.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W      = 9,
   parameter int DRAIN_CYC = 2
)(
   input  logic          clk,
   input  logic          rst_n,
   pc_sequencer_if.slave bus
);

   localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [DC_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;
   logic            fetch_valid;
   logic            flush_if_id;
   logic            flush_id_ex;

   // Upper target bits are outside the instruction address space.
   assign target  = bus.redirect_pc[PC_W-1:0];
   assign pc_next = pc_q + PC_W'(PC_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      fetch_valid = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      unique case (state_q)
         RUN: begin
            fetch_valid = 1'b1;
            if (bus.halt) begin
               pc_d        = target;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
               cnt_d       = DC_W'(DRAIN_CYC - 1);
               state_d     = DRAIN;
            end else if (bus.redirect) begin
               pc_d        = target;
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else if (!bus.stall) begin
               pc_d = pc_next;
            end
         end
         DRAIN: begin
            // Keep squashing IF/ID while MEM/WB retire.
            flush_if_id = 1'b1;
            if (cnt_q == '0)
               state_d = HALTED;
            else
               cnt_d = cnt_q - 1'b1;
         end
         HALTED: begin
            flush_if_id = 1'b1;
            if (bus.resume) begin
               pc_d    = pc_next;
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid;
   assign bus.flush_if_id = flush_if_id;
   assign bus.flush_id_ex = flush_id_ex;
   assign bus.draining    = (state_q == DRAIN);
   assign bus.halted      = (state_q == HALTED);

`ifdef PC_SEQUENCER_PERF_EN
   logic redirect_ev;
   logic stall_ev;

   assign redirect_ev = (state_q == RUN) && (bus.halt || bus.redirect);
   assign stall_ev    = (state_q == RUN) && bus.stall &&
                        !bus.halt && !bus.redirect;

   pc_sequencer_perf u_perf (
      .clk          (clk),
      .rst_n        (rst_n),
      .redirect_ev  (redirect_ev),
      .stall_ev     (stall_ev),
      .redirect_cnt (bus.redirect_cnt),
      .stall_cnt    (bus.stall_cnt)
   );
`else
   assign bus.redirect_cnt = '0;
   assign bus.stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors feed a scoreboard queue; a negedge monitor
// pops and compares the expected outputs of every driven cycle.
module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

`ifdef PC_SEQUENCER_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct {
      string       name;
      bit          rst_n;
      bit          stall;
      bit          redirect;
      bit          halt;
      bit          resume;
      logic [31:0] rpc;
      logic [8:0]  pc;
      bit          fv;
      bit          fif;
      bit          fie;
      bit          dr;
      bit          ht;
      int unsigned rc;
      int unsigned sc;
   } vec_t;

   logic clk;
   logic rst_n;

   pc_sequencer_if #(.PC_W(9)) bus ();

   pc_sequencer #(
      .PC_W      (9),
      .DRAIN_CYC (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic add(input string n, input bit r, input bit st,
                      input bit rd, input bit h, input bit rs,
                      input logic [31:0] rpc, input logic [8:0] pc,
                      input bit fv, input bit fif, input bit fie,
                      input bit dr, input bit ht,
                      input int unsigned rc, input int unsigned sc);
      vec_t v;
      v.name = n; v.rst_n = r; v.stall = st; v.redirect = rd;
      v.halt = h; v.resume = rs; v.rpc = rpc; v.pc = pc;
      v.fv = fv; v.fif = fif; v.fie = fie; v.dr = dr; v.ht = ht;
      v.rc = PERF ? rc : 0;
      v.sc = PERF ? sc : 0;
      vecs.push_back(v);
   endtask

   // Monitor: every driven cycle presents outputs; compare at negedge.
   initial begin
      vec_t e;
      logic [8:0]  g_pc;
      logic [4:0]  g_fl, e_fl;
      logic [31:0] g_rc, g_sc;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            g_pc = bus.pc;
            g_fl = {bus.fetch_valid, bus.flush_if_id, bus.flush_id_ex,
                    bus.draining, bus.halted};
            e_fl = {e.fv, e.fif, e.fie, e.dr, e.ht};
            g_rc = bus.redirect_cnt;
            g_sc = bus.stall_cnt;
            n_cmp++;
            if (g_pc !== e.pc || g_fl !== e_fl ||
                g_rc !== e.rc || g_sc !== e.sc) begin
               n_bad++;
               $display("FAIL %s: got pc=%h fv/fif/fie/dr/ht=%b rc=%0d sc=%0d, want pc=%h fv/fif/fie/dr/ht=%b rc=%0d sc=%0d",
                        e.name, g_pc, g_fl, g_rc, g_sc,
                        e.pc, e_fl, e.rc, e.sc);
            end
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.halt        = 1'b0;
      bus.resume      = 1'b0;
      bus.redirect_pc = '0;

      //   name          rst st rd h rs rpc            pc      fv fif fie dr ht rc sc
      add("run0",        1, 0, 0, 0, 0, 32'h0,         9'd0,   1, 0, 0, 0, 0, 0, 0);
      add("run4",        1, 0, 0, 0, 0, 32'h0,         9'd4,   1, 0, 0, 0, 0, 0, 0);
      add("run8",        1, 0, 0, 0, 0, 32'h0,         9'd8,   1, 0, 0, 0, 0, 0, 0);
      add("run12",       1, 0, 0, 0, 0, 32'h0,         9'd12,  1, 0, 0, 0, 0, 0, 0);
      add("run16",       1, 0, 0, 0, 0, 32'h0,         9'd16,  1, 0, 0, 0, 0, 0, 0);
      add("redir_hi",    1, 0, 1, 0, 0, 32'hFFFF_FFFC, 9'd20,  1, 1, 1, 0, 0, 0, 0);
      add("at508",       1, 0, 0, 0, 0, 32'h0,         9'd508, 1, 0, 0, 0, 0, 1, 0);
      add("wrap0",       1, 0, 0, 0, 0, 32'h0,         9'd0,   1, 0, 0, 0, 0, 1, 0);
      add("post_wrap4",  1, 0, 0, 0, 0, 32'h0,         9'd4,   1, 0, 0, 0, 0, 1, 0);
      add("stall_redir", 1, 1, 1, 0, 0, 32'h0000_0240, 9'd8,   1, 1, 1, 0, 0, 1, 0);
      add("redir_12",    1, 0, 1, 0, 0, 32'h0000_000C, 9'h040, 1, 1, 1, 0, 0, 2, 0);
      add("stall1",      1, 1, 0, 0, 0, 32'h0,         9'd12,  1, 0, 0, 0, 0, 3, 0);
      add("stall2",      1, 1, 0, 0, 0, 32'h0,         9'd12,  1, 0, 0, 0, 0, 3, 1);
      add("stall3",      1, 1, 0, 0, 0, 32'h0,         9'd12,  1, 0, 0, 0, 0, 3, 2);
      add("unstall",     1, 0, 0, 0, 0, 32'h0,         9'd12,  1, 0, 0, 0, 0, 3, 3);
      add("halt",        1, 1, 0, 1, 0, 32'h0000_0020, 9'd16,  1, 1, 1, 0, 0, 3, 3);
      add("drain1",      1, 1, 1, 0, 0, 32'h0000_0100, 9'h020, 0, 1, 0, 1, 0, 4, 3);
      add("drain2",      1, 0, 0, 0, 1, 32'h0,         9'h020, 0, 1, 0, 1, 0, 4, 3);
      add("halted",      1, 0, 1, 1, 0, 32'h0000_0080, 9'h020, 0, 1, 0, 0, 1, 4, 3);
      add("resume",      1, 0, 0, 0, 1, 32'h0,         9'h020, 0, 1, 0, 0, 1, 4, 3);
      add("run24",       1, 0, 0, 0, 0, 32'h0,         9'h024, 1, 0, 0, 0, 0, 4, 3);
      add("halt2",       1, 0, 0, 1, 0, 32'h0000_0100, 9'h028, 1, 1, 1, 0, 0, 4, 3);
      add("drain_b",     1, 0, 0, 0, 0, 32'h0,         9'h100, 0, 1, 0, 1, 0, 5, 3);
      add("rst_drain",   0, 0, 0, 0, 0, 32'h0,         9'd0,   1, 0, 0, 0, 0, 0, 0);
      add("rel0",        1, 0, 0, 0, 0, 32'h0,         9'd0,   1, 0, 0, 0, 0, 0, 0);
      add("rel4",        1, 0, 0, 0, 0, 32'h0,         9'd4,   1, 0, 0, 0, 0, 0, 0);
      add("rel8",        1, 0, 0, 0, 0, 32'h0,         9'd8,   1, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         rst_n           = vecs[i].rst_n;
         bus.stall       = vecs[i].stall;
         bus.redirect    = vecs[i].redirect;
         bus.halt        = vecs[i].halt;
         bus.resume      = vecs[i].resume;
         bus.redirect_pc = vecs[i].rpc;
         exp_q.push_back(vecs[i]);
         @(posedge clk);
         #1;
      end
      bus.stall    = 1'b0;
      bus.redirect = 1'b0;
      bus.halt     = 1'b0;
      bus.resume   = 1'b0;

      for (int k = 0; k < 5 && exp_q.size() > 0; k++)
         @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
